// File: rtl/wiper_motor_seq.sv
// Wiper arm sequencer: sweeps a simulated arm park->top->park at the commanded
// rate, always completes a sweep before parking, and counts completed sweeps.
module wiper_motor_seq #(
  parameter int unsigned POS_MAX  = 7,
  parameter int unsigned SLOW_DIV = 4,
  parameter int unsigned FAST_DIV = 1
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic [1:0] limpador,
  input  logic       trava,
  output logic [2:0] posicao,
  output logic [7:0] led_bar,
  output logic       motor_on,
  output logic       direcao,
  output logic       parked,
  output logic [7:0] sweep_cnt
);

  localparam int unsigned TW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_DIV - 1);
  localparam logic [TW-1:0] FAST_LAST = TW'(FAST_DIV - 1);
  localparam logic [2:0]    POS_TOP   = 3'(POS_MAX);

  typedef enum logic [1:0] {
    PARK       = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      pos_q, pos_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            fast_q, fast_d;     // speed register: 0 slow, 1 fast
  logic [7:0]      cnt_q, cnt_d;

  logic            cmd_on_c;
  logic            cmd_fast_c;
  logic [TW-1:0]   timer_last_c;
  logic            step_c;

  // Command decode and step divider terminal count
  always_comb begin
    cmd_on_c     = (limpador != 2'b00);
    cmd_fast_c   = (limpador != 2'b01);
    timer_last_c = fast_q ? FAST_LAST : SLOW_LAST;
    step_c       = (timer_q == timer_last_c);
  end

  // Next-state: sweep sequencing, arm stepping, speed sampling, sweep counting
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    timer_d = timer_q;
    fast_d  = fast_q;
    cnt_d   = cnt_q;
    if (!trava) begin
      unique case (state_q)
        PARK: begin
          if (cmd_on_c) begin
            fast_d  = cmd_fast_c;
            timer_d = '0;
            state_d = SWEEP_UP;
          end
        end
        SWEEP_UP: begin
          if (step_c) begin
            timer_d = '0;
            pos_d   = pos_q + 3'd1;
            if ((pos_q + 3'd1) == POS_TOP) begin
              state_d = SWEEP_DOWN;
              if (cmd_on_c) fast_d = cmd_fast_c;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        SWEEP_DOWN: begin
          if (step_c) begin
            timer_d = '0;
            pos_d   = pos_q - 3'd1;
            if (pos_q == 3'd1) begin
              cnt_d = cnt_q + 8'd1;
              if (cmd_on_c) begin
                fast_d  = cmd_fast_c;
                state_d = SWEEP_UP;
              end else begin
                state_d = PARK;
              end
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = PARK;
          pos_d   = 3'd0;
          timer_d = '0;
        end
      endcase
    end
  end

  // State registers; reset snaps the arm to park immediately
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q <= PARK;
      pos_q   <= 3'd0;
      timer_q <= '0;
      fast_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      timer_q <= timer_d;
      fast_q  <= fast_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decodes of registered state only
  always_comb begin
    posicao   = pos_q;
    led_bar   = 8'd1 << pos_q;
    motor_on  = (state_q == SWEEP_UP) || (state_q == SWEEP_DOWN);
    direcao   = (state_q == SWEEP_UP);
    parked    = (state_q == PARK);
    sweep_cnt = cnt_q;
  end

endmodule

// File: tb/tb_wiper_motor_seq.sv
// Bench for wiper_motor_seq: directed timing scenarios plus random traffic,
// scored against a stroke-timing model.
module tb_wiper_motor_seq;

  localparam int POS_MAX  = 7;
  localparam int SLOW_DIV = 4;
  localparam int FAST_DIV = 1;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic [1:0] limpador;
  logic       trava;
  logic [2:0] posicao;
  logic [7:0] led_bar;
  logic       motor_on;
  logic       direcao;
  logic       parked;
  logic [7:0] sweep_cnt;

  wiper_motor_seq #(.POS_MAX(POS_MAX), .SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV)) dut (
    .clk_2(clk_2), .reset(reset), .limpador(limpador), .trava(trava),
    .posicao(posicao), .led_bar(led_bar), .motor_on(motor_on),
    .direcao(direcao), .parked(parked), .sweep_cnt(sweep_cnt)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct packed {
    logic [2:0] pos;
    logic [7:0] led;
    logic       mot;
    logic       dir;
    logic       park;
    logic [7:0] cnt;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Stroke model: an active stroke lasts POS_MAX*div cycles; position is elapsed/div
  int m_active, m_up, m_div, m_t, m_cnt;

  function automatic int dec_div(input logic [1:0] l);
    return (l == 2'b01) ? SLOW_DIV : FAST_DIV;
  endfunction

  function automatic void model_reset();
    m_active = 0; m_up = 0; m_div = SLOW_DIV; m_t = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(input logic [1:0] lim, input logic trv, input logic rst);
    if (!rst) begin
      model_reset();
    end else if (!trv) begin
      if (m_active == 0) begin
        if (lim != 2'b00) begin
          m_active = 1; m_up = 1; m_div = dec_div(lim); m_t = 0;
        end
      end else begin
        m_t = m_t + 1;
        if (m_t == POS_MAX * m_div) begin
          m_t = 0;
          if (m_up != 0) begin
            m_up = 0;
            if (lim != 2'b00) m_div = dec_div(lim);
          end else begin
            m_cnt = (m_cnt + 1) % 256;
            if (lim != 2'b00) begin
              m_div = dec_div(lim); m_up = 1;
            end else begin
              m_active = 0;
            end
          end
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    int   p;
    if (m_active == 0)  p = 0;
    else if (m_up != 0) p = m_t / m_div;
    else                p = POS_MAX - m_t / m_div;
    o.pos  = 3'(p);
    o.led  = 8'd1 << p;
    o.mot  = (m_active != 0);
    o.dir  = (m_active != 0) && (m_up != 0);
    o.park = (m_active == 0);
    o.cnt  = 8'(m_cnt);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pos = posicao; o.led = led_bar; o.mot = motor_on;
    o.dir = direcao; o.park = parked; o.cnt = sweep_cnt;
    return o;
  endfunction

  task automatic check_obs(input string tag, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got pos=%0d led=%h mot=%b dir=%b park=%b cnt=%0d, required pos=%0d led=%h mot=%b dir=%b park=%b cnt=%0d",
               tag, $time, a.pos, a.led, a.mot, a.dir, a.park, a.cnt,
               e.pos, e.led, e.mot, e.dir, e.park, e.cnt);
    end
  endtask

  task automatic dchk(input string tag, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, required %0d", tag, $time, act, req);
    end
  endtask

  // Monitor: one expected observation per clock, compared on the falling edge
  always @(negedge clk_2) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_obs("scoreboard", dut_obs(), e);
    end
  end

  // One clock: drive after the falling edge, predict after the rising edge
  task automatic cycle(input logic [1:0] lim, input logic trv, input logic rst);
    @(negedge clk_2);
    #1;
    limpador = lim; trava = trv; reset = rst;
    @(posedge clk_2);
    #1;
    model_step(lim, trv, rst);
    exp_q.push_back(model_obs());
  endtask

  task automatic run_n(input logic [1:0] lim, input logic trv, input int n);
    repeat (n) cycle(lim, trv, 1'b1);
  endtask

  task automatic do_reset();
    cycle(2'b00, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b1);
  endtask

  // Reset pulse between edges; the arm must snap to park without a clock
  task automatic pulse_reset();
    obs_t dummy;
    #2;
    reset = 1'b0;
    #1;
    dchk("async_rst_pos", int'(posicao), 0);
    dchk("async_rst_parked", int'(parked), 1);
    dchk("async_rst_led", int'(led_bar), 1);
    reset = 1'b1;
    model_reset();
    dummy = exp_q.pop_back();
    exp_q.push_back(model_obs());
  endtask

  initial begin
    logic [1:0] lim;
    logic       trv;
    logic       rst;
    reset = 1'b0; limpador = 2'b00; trava = 1'b0;
    model_reset();

    // Reset held with random command/freeze inputs
    for (int i = 0; i < 6; i++) cycle(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    dchk("rst_pos", int'(posicao), 0);
    dchk("rst_led", int'(led_bar), 8'h01);
    dchk("rst_parked", int'(parked), 1);
    dchk("rst_motor", int'(motor_on), 0);
    dchk("rst_cnt", int'(sweep_cnt), 0);
    cycle(2'b00, 1'b0, 1'b1);

    // Slow continuous sweeps
    cycle(2'b01, 1'b0, 1'b1);
    run_n(2'b01, 1'b0, 4);
    dchk("slow_first_step", int'(posicao), 1);
    run_n(2'b01, 1'b0, 24);
    dchk("slow_top_pos", int'(posicao), POS_MAX);
    dchk("slow_top_dir", int'(direcao), 0);
    run_n(2'b01, 1'b0, 28);
    dchk("slow_bottom_pos", int'(posicao), 0);
    dchk("slow_bottom_cnt", int'(sweep_cnt), 1);
    dchk("slow_restroke_dir", int'(direcao), 1);
    run_n(2'b01, 1'b0, 112);
    dchk("slow_three_sweeps", int'(sweep_cnt), 3);

    // Fast sweeps and counter wrap
    do_reset();
    cycle(2'b10, 1'b0, 1'b1);
    run_n(2'b10, 1'b0, 1);
    dchk("fast_first_step", int'(posicao), 1);
    run_n(2'b10, 1'b0, 13);
    dchk("fast_bottom_pos", int'(posicao), 0);
    dchk("fast_bottom_cnt", int'(sweep_cnt), 1);
    run_n(2'b11, 1'b0, 14 * 17);
    dchk("fast_18_sweeps", int'(sweep_cnt), 18);
    run_n(2'b10, 1'b0, 14 * 238);
    dchk("fast_wrap", int'(sweep_cnt), 0);

    // Stop mid-stroke: must finish the sweep then park
    do_reset();
    cycle(2'b01, 1'b0, 1'b1);
    run_n(2'b01, 1'b0, 12);
    dchk("stop_at3", int'(posicao), 3);
    run_n(2'b00, 1'b0, 44);
    dchk("stop_parked", int'(parked), 1);
    dchk("stop_motor", int'(motor_on), 0);
    dchk("stop_cnt", int'(sweep_cnt), 1);
    run_n(2'b00, 1'b0, 20);
    dchk("stop_still_parked", int'(posicao), 0);

    // Speed change slow->fast mid-stroke
    do_reset();
    cycle(2'b01, 1'b0, 1'b1);
    run_n(2'b01, 1'b0, 8);
    run_n(2'b10, 1'b0, 20);
    dchk("chg_top_pos", int'(posicao), POS_MAX);
    run_n(2'b10, 1'b0, 2);
    run_n(2'b01, 1'b0, 5);
    dchk("chg_bottom_pos", int'(posicao), 0);
    dchk("chg_bottom_cnt", int'(sweep_cnt), 1);
    run_n(2'b01, 1'b0, 4);
    dchk("chg_back_slow", int'(posicao), 1);

    // Freeze for 10 cycles at position 5 mid-step
    do_reset();
    cycle(2'b01, 1'b0, 1'b1);
    run_n(2'b01, 1'b0, 22);
    run_n(2'b01, 1'b1, 10);
    dchk("frz_hold_pos", int'(posicao), 5);
    run_n(2'b01, 1'b0, 1);
    dchk("frz_resume_wait", int'(posicao), 5);
    run_n(2'b01, 1'b0, 1);
    dchk("frz_resume_step", int'(posicao), 6);
    run_n(2'b01, 1'b0, 32);
    dchk("frz_total_pos", int'(posicao), 0);
    dchk("frz_total_cnt", int'(sweep_cnt), 1);

    // Asynchronous reset mid-sweep at position 4
    do_reset();
    cycle(2'b01, 1'b0, 1'b1);
    run_n(2'b01, 1'b0, 16);
    dchk("pre_pulse_pos", int'(posicao), 4);
    pulse_reset();
    run_n(2'b00, 1'b0, 3);

    // Random traffic against the model
    lim = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) lim = 2'($urandom_range(0, 3));
      trv = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) != 0);
      cycle(lim, trv, rst);
    end

    @(negedge clk_2);
    #1;
    dchk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wiper_motor_seq.md
Name: wiper_motor_seq

Overview:
- Downstream stage of the rain/wiper-speed decoder. Consumes the 2-bit wiper speed command (`limpador`: 0 off, 1 slow, 2 fast).
- Drives a simulated wiper arm: sweeps it from park to top and back at the commanded rate.
- Always completes a sweep before parking. Counts completed sweeps.
- Outputs feed the board LEDs (one-hot arm position) and the debug bus.

Parameters:
- POS_MAX, 7, top-of-arc position; arm positions are 0..POS_MAX, where 0 = park. Range 1..7.
- SLOW_DIV, 4, clock cycles per arm step at slow speed (>=1).
- FAST_DIV, 1, clock cycles per arm step at fast speed (>=1, <=SLOW_DIV).

Ports:
- clk_2  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, regardless of clock).
- limpador  input  2  speed command: 00 off, 01 slow, 10 fast, 11 treated as fast.
- trava  input  1  freeze; when 1, all state holds.
- posicao  output  3  current arm position, 0..POS_MAX.
- led_bar  output  8  one-hot of posicao (bit posicao set).
- motor_on  output  1  1 in SWEEP_UP/SWEEP_DOWN.
- direcao  output  1  1 in SWEEP_UP, 0 otherwise.
- parked  output  1  1 in PARK.
- sweep_cnt  output  8  completed full sweeps, wraps 255->0.

Behaviour:
- Reset (reset=0, async) forces:
  - state=PARK, posicao=0, timer=0, spd_reg=slow, sweep_cnt=0.
  - motor_on=0, direcao=0, parked=1, led_bar=8'h01.
  - Reset mid-sweep snaps the arm to 0 immediately; no completion.
- All outputs are registered state or pure decodes of state/posicao; no combinational path from inputs to outputs.
- Step divider:
  - div = SLOW_DIV if spd_reg=slow, else FAST_DIV.
  - In a sweep state, each edge: if timer==div-1, then timer<=0 and a step occurs; else timer<=timer+1.
  - With div=1, a step occurs every edge.
  - timer width is clog2(SLOW_DIV), minimum 1 bit.
- trava=1: timer, state, posicao, spd_reg and sweep_cnt all hold. Resume continues with the exact timer value. Async reset still overrides.
- States:
  - PARK: if limpador!=0, latch spd_reg (01->slow, else fast), set timer<=0, go to SWEEP_UP. Otherwise stay. posicao stays 0.
  - SWEEP_UP: on a step, posicao<=posicao+1. When the step makes posicao==POS_MAX, go to SWEEP_DOWN on the same edge. At that reversal edge, if limpador!=0, spd_reg<=decoded limpador; if limpador==0, spd_reg is kept.
  - SWEEP_DOWN: on a step, posicao<=posicao-1. When the step makes posicao==0:
    - sweep_cnt<=sweep_cnt+1.
    - If limpador!=0: spd_reg<=decoded limpador, timer<=0, stay sweeping (go to SWEEP_UP, no dwell).
    - Else go to PARK.
- Speed command sampling points: PARK exit, top reversal, and bottom return only. Command changes mid-stroke do not alter the current stroke.
- Command 00 mid-sweep: the arm finishes to top, returns to 0, then parks. Never parks mid-arc.
- Timing:
  - First step occurs div edges after the PARK-exit edge.
  - Arm is at 0 again exactly 2*POS_MAX*div edges after the PARK-exit edge (slow default: 56; fast: 14).
- Wrap: sweep_cnt 255+1 -> 0, no flag.
- posicao never exceeds POS_MAX or goes below 0 in any path.

Test Plan:
- Reset: hold reset=0 with random limpador/trava -> posicao=0, led_bar=8'h01, parked=1, motor_on=0, sweep_cnt=0. Pulse reset=0 between clock edges during a sweep at posicao=4 -> posicao=0 immediately, parked=1.
- Slow continuous, limpador=01, defaults:
  - PARK exit at edge E.
  - posicao=1 at E+4; posicao=7 and direcao=0 at E+28.
  - posicao=0 and sweep_cnt=1 at E+56, then direcao=1 next stroke.
  - sweep_cnt=3 at E+168.
- Fast, limpador=10: posicao increments every edge. posicao=0 and sweep_cnt=1 at E+14. 18 consecutive sweeps give sweep_cnt=18. Force 256 sweeps -> sweep_cnt wraps to 0.
- Stop mid-stroke, slow: drop limpador to 00 when posicao=3 upward -> continues to 7, returns to 0, enters PARK at E+56 with sweep_cnt=1, motor_on=0. No further motion while limpador=00.
- Speed change, slow->fast when posicao=2 upward:
  - Remainder of up-stroke stays at 4 cycles/step; top reached at E+28.
  - Down-stroke runs 1 cycle/step; posicao=0 at E+35.
  - Set limpador=01 at E+30 -> no effect until the bottom sample at E+35.
- Freeze: assert trava=1 at posicao=5 for 10 cycles -> posicao, timer and sweep_cnt unchanged throughout. After release, the next step occurs exactly the remaining timer count later. Total sweep time = nominal + 10.
